fetch_receive: RTL and testbench
================================

FETCH_RECEIVE -- requirements
Module: fetch_receive

Interface
REQ-001 SHALL have parameter CORE, default 0, core index (informational).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter ADDRESS_BITS, default 20, PC width.
REQ-004 SHALL have parameter NOP, default 32'h00000013, bubble instruction.
REQ-005 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port issue_PC  input  ADDRESS_BITS  PC presented to instruction memory this cycle.
REQ-008 SHALL have port issue_fire  input  1  a new fetch address was presented this cycle.
REQ-009 SHALL have port i_mem_data  input  DATA_WIDTH  synchronous-read data; valid one cycle after its address.
REQ-010 SHALL have port flush  input  1  redirect; discard all buffered and in-flight fetches.
REQ-011 SHALL have port decode_ready  input  1  downstream accepts the instruction this cycle.
REQ-012 SHALL have port instruction  output  DATA_WIDTH  head instruction, NOP when not valid.
REQ-013 SHALL have port inst_PC  output  ADDRESS_BITS  PC of head instruction, 0 when not valid.
REQ-014 SHALL have port inst_valid  output  1  head entry valid.
REQ-015 SHALL have port fetch_stall  output  1  request upstream to hold PC (next_PC_select = stall).

Function
REQ-016 SHALL capture issue_PC into pending_PC and set pending_valid when issue_fire=1 and (fetch_stall=0 or flush=1); otherwise clear pending_valid.
REQ-017 SHALL, in the cycle after capture with pending_valid=1, push {pending_PC, i_mem_data} into a 2-entry in-order buffer.
REQ-018 SHALL track occupancy as states EMPTY(0), ONE(1), FULL(2); push only: +1; pop only: -1; push and pop same cycle: unchanged.
REQ-019 SHALL pop when inst_valid=1 and decode_ready=1; inst_valid = (state != EMPTY).
REQ-020 SHALL drive instruction/inst_PC from buffer head combinationally; NOP and 0 when EMPTY.
REQ-021 SHALL compute fetch_stall = (count + pending_valid - pop) >= 2, combinationally, guaranteeing no push into FULL without a simultaneous pop.
REQ-022 SHALL sustain one instruction per cycle with decode_ready held 1; issue-to-inst_valid latency 2 cycles.
REQ-023 SHALL, on flush=1, next cycle empty the buffer, drop any push from the prior pending fetch, and keep only a same-cycle issue_fire capture.
REQ-024 SHALL ignore decode_ready while EMPTY (no pop, no underflow).
REQ-025 SHALL wrap buffer read/write pointers modulo 2.

Reset
REQ-026 SHALL on reset=1 at clock edge clear state to EMPTY, pointers to 0, pending_valid to 0.
REQ-027 SHALL present after reset instruction=NOP, inst_PC=0, inst_valid=0, fetch_stall=0.
REQ-028 SHALL give reset priority over flush, issue_fire and pop, including mid-operation with FULL buffer.

Structure
REQ-029 SHALL take NOP value and EMPTY/ONE/FULL encodings from the shared core constants include file.
REQ-030 SHALL implement the buffer as one sub-module, fetch_buffer (2-entry, PC+instruction wide, push/pop/clear).

Verification
REQ-031 SHALL verify reset: reset=1 two cycles -> instruction=32'h00000013, inst_PC=0, inst_valid=0, fetch_stall=0.
REQ-032 SHALL verify streaming: issue_fire every cycle with PC 0,4,8, memory returns A,B,C, decode_ready=1 -> inst_valid from cycle 2, (0,A),(4,B),(8,C) in consecutive cycles, fetch_stall=0 throughout.
REQ-033 SHALL verify backpressure: decode_ready=0 while issuing PC 0,4 -> FULL after two pushes, fetch_stall=1, head stays (0,A); decode_ready=1 -> (0,A) then (4,B), no loss or duplication.
REQ-034 SHALL verify flush: buffer FULL with (0,A),(4,B), pending PC 8, flush=1 with issue_fire PC 0x100 -> next cycle inst_valid=0, then (0x100, data@0x100) only.
REQ-035 SHALL verify reset mid-operation: FULL buffer plus pending fetch, reset=1 one cycle -> all outputs at reset values, prior entries never appear.

Source files
------------

// File: rtl/fetch_receive_pkg.sv
// Shared core constants for the fetch receive path: the bubble instruction
// and the occupancy encoding of the two-entry fetch buffer.
package fetch_receive_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/fetch_receive_if.sv
// Fetch-side bundle: issue/memory inputs toward the receive stage and the
// head-of-buffer instruction plus stall request coming back out.
interface fetch_receive_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic [ADDRESS_BITS-1:0] issue_PC;
  logic                    issue_fire;
  logic [DATA_WIDTH-1:0]   i_mem_data;
  logic                    flush;
  logic                    decode_ready;
  logic [DATA_WIDTH-1:0]   instruction;
  logic [ADDRESS_BITS-1:0] inst_PC;
  logic                    inst_valid;
  logic                    fetch_stall;

  modport master (
    output issue_PC, issue_fire, i_mem_data, flush, decode_ready,
    input  instruction, inst_PC, inst_valid, fetch_stall
  );

  modport slave (
    input  issue_PC, issue_fire, i_mem_data, flush, decode_ready,
    output instruction, inst_PC, inst_valid, fetch_stall
  );
endinterface

// File: rtl/fetch_receive_buffer.sv
// Two-entry in-order buffer of {PC, instruction}; clear empties it in one
// cycle and takes priority over push and pop.
module fetch_buffer
  import fetch_receive_pkg::*;
#(
  parameter int WIDTH = 52
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output occ_e             state_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  occ_e             state_q, state_d;
  logic             pop_eff;

  // A pop request while empty is ignored so occupancy never underflows.
  assign pop_eff = pop_i && (state_q != EMPTY);

  always_comb begin
    state_d = state_q;
    unique case ({push_i, pop_eff})
      2'b10: state_d = (state_q == EMPTY) ? ONE : FULL;
      2'b01: state_d = (state_q == FULL) ? ONE : EMPTY;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_i)  wr_ptr_q <= ~wr_ptr_q;
      if (pop_eff) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign state_o = state_q;

endmodule

// File: rtl/fetch_receive.sv
// Fetch receive stage: pairs each issued PC with the synchronous-read memory
// word one cycle later and buffers the pair until decode accepts it.
module fetch_receive
  import fetch_receive_pkg::*;
#(
  parameter int                    CORE         = 0,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDRESS_BITS = 20,
  parameter logic [DATA_WIDTH-1:0] NOP          = DATA_WIDTH'(NOP_INST)
) (
  input logic             clock,
  input logic             reset,
  fetch_receive_if.slave  bus
);

  localparam int ENTRY_W = ADDRESS_BITS + DATA_WIDTH;

  logic                    core_unused;
  logic [ADDRESS_BITS-1:0] pending_PC_q, pending_PC_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [ENTRY_W-1:0]      head;
  occ_e                    state;
  logic                    inst_valid;
  logic                    pop;
  logic                    push;
  logic [2:0]              fill;

  assign core_unused = (CORE != 0);

  assign inst_valid = (state != EMPTY);
  assign pop        = inst_valid && bus.decode_ready;
  // A flush discards the word returning for the previous fetch.
  assign push       = pending_valid_q && !bus.flush;

  // Occupancy after this edge, counting the fetch whose data is in flight.
  assign fill = {1'b0, 2'(state)} + {2'b00, pending_valid_q} - {2'b00, pop};
  assign bus.fetch_stall = (fill >= 3'd2);

  always_comb begin
    pending_valid_d = bus.issue_fire && (!bus.fetch_stall || bus.flush);
    pending_PC_d    = pending_valid_d ? bus.issue_PC : pending_PC_q;
  end

  always_ff @(posedge clock) begin
    if (reset) pending_valid_q <= 1'b0;
    else       pending_valid_q <= pending_valid_d;
  end

  always_ff @(posedge clock) begin
    pending_PC_q <= pending_PC_d;
  end

  fetch_buffer #(
    .WIDTH (ENTRY_W)
  ) u_buffer (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (bus.flush),
    .wdata_i ({pending_PC_q, bus.i_mem_data}),
    .rdata_o (head),
    .state_o (state)
  );

  assign bus.inst_valid  = inst_valid;
  assign bus.instruction = inst_valid ? head[DATA_WIDTH-1:0] : NOP;
  assign bus.inst_PC     = inst_valid ? head[ENTRY_W-1:DATA_WIDTH] : '0;

endmodule

// File: tb/tb_fetch_receive.sv
// Scoreboard bench for fetch_receive: directed scenarios followed by random
// issue/flush/backpressure/reset traffic against a queue-level model.
module tb_fetch_receive;

  localparam logic [31:0] NOP_EXP = 32'h00000013;

  typedef struct packed {
    logic [19:0] pc;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Accepted fetches not yet consumed, oldest first; the newest one is still
  // waiting on memory when 'pend' is set.
  ent_t exp_q[$];
  bit   pend = 1'b0;

  fetch_receive_if bus ();

  fetch_receive dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [19:0] pc);
    return {pc[11:0], pc} ^ 32'h5A3C_0F96;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) bus.i_mem_data <= memf(bus.issue_PC);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input bit f, input logic [19:0] pc, input bit fl,
                      input bit dr, input bit r);
    @(posedge clk);
    #1;
    bus.issue_fire   = f;
    bus.issue_PC     = pc;
    bus.flush        = fl;
    bus.decode_ready = dr;
    rst              = r;
  endtask

  // Monitor: compare outputs against the model, then advance the model.
  initial begin
    int   buffered;
    bit   v_exp, pop, stall_exp;
    ent_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        buffered  = exp_q.size() - int'(pend);
        v_exp     = (buffered > 0);
        pop       = v_exp && bus.decode_ready;
        stall_exp = (exp_q.size() - int'(pop)) >= 2;
        chk("inst_valid", 64'(bus.inst_valid), 64'(v_exp));
        chk("fetch_stall", 64'(bus.fetch_stall), 64'(stall_exp));
        if (v_exp) begin
          chk("instruction", 64'(bus.instruction), 64'(exp_q[0].data));
          chk("inst_PC", 64'(bus.inst_PC), 64'(exp_q[0].pc));
        end else begin
          chk("instruction_nop", 64'(bus.instruction), 64'(NOP_EXP));
          chk("inst_PC_zero", 64'(bus.inst_PC), 64'd0);
        end
        if (rst) begin
          exp_q.delete();
          pend = 1'b0;
        end else if (bus.flush) begin
          exp_q.delete();
          pend = bus.issue_fire;
          if (bus.issue_fire) begin
            e.pc = bus.issue_PC; e.data = memf(bus.issue_PC);
            exp_q.push_back(e);
          end
        end else begin
          if (pop) void'(exp_q.pop_front());
          pend = bus.issue_fire && !stall_exp;
          if (pend) begin
            e.pc = bus.issue_PC; e.data = memf(bus.issue_PC);
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst              = 1'b1;
    bus.issue_fire   = 1'b0;
    bus.issue_PC     = '0;
    bus.flush        = 1'b0;
    bus.decode_ready = 1'b0;
    bus.i_mem_data   = '0;
    step(0, 20'h0, 0, 0, 1);
    step(0, 20'h0, 0, 1, 0);
    step(0, 20'h0, 0, 1, 0);
    // Streaming at full rate.
    step(1, 20'h0, 0, 1, 0);
    step(1, 20'h4, 0, 1, 0);
    step(1, 20'h8, 0, 1, 0);
    repeat (3) step(0, 20'h0, 0, 1, 0);
    // Backpressure until full, then drain.
    step(1, 20'h0, 0, 0, 0);
    step(1, 20'h4, 0, 0, 0);
    step(1, 20'h8, 0, 0, 0);
    repeat (2) step(0, 20'h0, 0, 0, 0);
    repeat (3) step(0, 20'h0, 0, 1, 0);
    // Fill, then flush with a same-cycle redirect fetch.
    step(1, 20'h0, 0, 0, 0);
    step(1, 20'h4, 0, 0, 0);
    step(1, 20'h8, 0, 1, 0);
    step(0, 20'h0, 0, 0, 0);
    step(1, 20'h100, 1, 0, 0);
    step(0, 20'h0, 0, 0, 0);
    repeat (3) step(0, 20'h0, 0, 1, 0);
    // Fill, then reset mid-operation with a fetch pending.
    step(1, 20'h0, 0, 0, 0);
    step(1, 20'h4, 0, 0, 0);
    step(1, 20'h8, 0, 1, 0);
    step(1, 20'hC, 1, 1, 1);
    repeat (4) step(0, 20'h0, 0, 1, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 70,
           20'($urandom_range(0, 4095) * 4),
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 60,
           $urandom_range(0, 199) < 1);
    end
    repeat (4) step(0, 20'h0, 0, 1, 0);
    @(posedge clk);
    done = 1'b1;
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
